// File: rtl/mem_stage_sram.sv
// MEM stage of the 5-stage ARM pipeline: LDR/STR over a 16-bit asynchronous SRAM as two
// half-word phases, stalling the pipeline via ready, followed by the MEM/WB pipeline register.
module mem_stage_sram #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       st_val_in,
  input  logic [3:0]        dest_in,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [31:0]       alu_res_out,
  output logic [31:0]       mem_data_out,
  output logic [3:0]        dest_out
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // BASE_ADDR is word aligned, so the word index can be formed without the byte-offset bits.
  localparam logic [ADDR_W-2:0] BASE_WORD = (ADDR_W-1)'(BASE_ADDR / 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-2:0] word_q, word_d;
  logic [31:0]       st_val_q, st_val_d;
  logic [31:0]       ld_buf_q, ld_buf_d;
  logic [ADDR_W-2:0] word_s;
  logic              ready_s;

  logic              wb_en_q, wb_en_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic [31:0]       alu_res_q, alu_res_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [3:0]        dest_q, dest_d;

  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       sram_dq_out_q, sram_dq_out_d;
  logic              sram_dq_oe_q, sram_dq_oe_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic              sram_oe_n_q, sram_oe_n_d;

  assign word_s = alu_res_in[ADDR_W:2] - BASE_WORD;

  // Access sequencer: next state, phase counter, request latches and load buffer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    st_val_d = st_val_q;
    ld_buf_d = ld_buf_q;
    ready_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_s = ~(mem_r_en_in | mem_w_en_in);
        cnt_d   = CNT_ZERO;
        if (mem_r_en_in) begin
          state_d  = S_RD_LO;
          word_d   = word_s;
          st_val_d = st_val_in;
        end else if (mem_w_en_in) begin
          state_d  = S_WR_LO;
          word_d   = word_s;
          st_val_d = st_val_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (state_q == S_RD_LO) begin
            ld_buf_d[15:0] = sram_dq_in;
            state_d        = S_RD_HI;
          end else if (state_q == S_RD_HI) begin
            ld_buf_d[31:16] = sram_dq_in;
            state_d         = S_DONE;
          end else if (state_q == S_WR_LO) begin
            state_d = S_WR_HI;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        ready_s = 1'b1;
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
      default: begin
        ready_s = 1'b1;
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM pins are registered from the next state so they are glitch-free for the async part.
  always_comb begin
    sram_addr_d   = '0;
    sram_dq_out_d = 16'h0000;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    sram_oe_n_d   = 1'b1;
    case (state_d)
      S_RD_LO: begin
        sram_addr_d = {word_d, 1'b0};
        sram_oe_n_d = 1'b0;
      end
      S_RD_HI: begin
        sram_addr_d = {word_d, 1'b1};
        sram_oe_n_d = 1'b0;
      end
      S_WR_LO: begin
        sram_addr_d   = {word_d, 1'b0};
        sram_dq_out_d = st_val_d[15:0];
        sram_dq_oe_d  = 1'b1;
        sram_we_n_d   = (cnt_d == CNT_LAST);
      end
      S_WR_HI: begin
        sram_addr_d   = {word_d, 1'b1};
        sram_dq_out_d = st_val_d[31:16];
        sram_dq_oe_d  = 1'b1;
        sram_we_n_d   = (cnt_d == CNT_LAST);
      end
      default: begin
        sram_addr_d = '0;
      end
    endcase
  end

  // MEM/WB register advances only when the pipeline is not frozen.
  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;
    if (ready_s) begin
      wb_en_d    = wb_en_in;
      mem_r_en_d = mem_r_en_in;
      alu_res_d  = alu_res_in;
      dest_d     = dest_in;
      if (mem_r_en_in) begin
        mem_data_d = ld_buf_q;
      end else begin
        mem_data_d = mem_data_q;
      end
    end else begin
      dest_d = dest_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= CNT_ZERO;
      word_q        <= '0;
      st_val_q      <= 32'h0000_0000;
      ld_buf_q      <= 32'h0000_0000;
      wb_en_q       <= 1'b0;
      mem_r_en_q    <= 1'b0;
      alu_res_q     <= 32'h0000_0000;
      mem_data_q    <= 32'h0000_0000;
      dest_q        <= 4'h0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= 16'h0000;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      st_val_q      <= st_val_d;
      ld_buf_q      <= ld_buf_d;
      wb_en_q       <= wb_en_d;
      mem_r_en_q    <= mem_r_en_d;
      alu_res_q     <= alu_res_d;
      mem_data_q    <= mem_data_d;
      dest_q        <= dest_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
    end
  end

  // While reset is held the pipeline is never frozen.
  assign ready        = rst ? ready_s : 1'b1;
  assign sram_addr    = sram_addr_q;
  assign sram_dq_out  = sram_dq_out_q;
  assign sram_dq_oe   = sram_dq_oe_q;
  assign sram_we_n    = sram_we_n_q;
  assign sram_oe_n    = sram_oe_n_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dest_out     = dest_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: instance A uses 4 wait cycles, instance B uses 2;
// each drives its own behavioural 16-bit SRAM.
module tb_mem_stage_sram;

  logic clk;
  logic rst;

  logic        a_wb_en, a_mem_r, a_mem_w;
  logic [31:0] a_alu, a_st;
  logic [3:0]  a_dest;
  logic        a_ready, a_dq_oe, a_we_n, a_oe_n, a_wb_en_o, a_mem_r_o;
  logic [17:0] a_addr;
  logic [15:0] a_dq_out, a_dq_in;
  logic [31:0] a_alu_o, a_data_o;
  logic [3:0]  a_dest_o;

  logic        b_wb_en, b_mem_r, b_mem_w;
  logic [31:0] b_alu, b_st;
  logic [3:0]  b_dest;
  logic        b_ready, b_dq_oe, b_we_n, b_oe_n, b_wb_en_o, b_mem_r_o;
  logic [17:0] b_addr;
  logic [15:0] b_dq_out, b_dq_in;
  logic [31:0] b_alu_o, b_data_o;
  logic [3:0]  b_dest_o;

  logic [15:0] mem_a [0:(1<<18)-1];
  logic [15:0] mem_b [0:(1<<18)-1];

  int errors;
  int checks;

  mem_stage_sram #(.BASE_ADDR(1024), .ADDR_W(18), .WAIT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .wb_en_in(a_wb_en), .mem_r_en_in(a_mem_r), .mem_w_en_in(a_mem_w),
    .alu_res_in(a_alu), .st_val_in(a_st), .dest_in(a_dest), .ready(a_ready),
    .sram_addr(a_addr), .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe), .sram_dq_in(a_dq_in),
    .sram_we_n(a_we_n), .sram_oe_n(a_oe_n), .wb_en_out(a_wb_en_o), .mem_r_en_out(a_mem_r_o),
    .alu_res_out(a_alu_o), .mem_data_out(a_data_o), .dest_out(a_dest_o)
  );

  mem_stage_sram #(.BASE_ADDR(1024), .ADDR_W(18), .WAIT_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .wb_en_in(b_wb_en), .mem_r_en_in(b_mem_r), .mem_w_en_in(b_mem_w),
    .alu_res_in(b_alu), .st_val_in(b_st), .dest_in(b_dest), .ready(b_ready),
    .sram_addr(b_addr), .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in),
    .sram_we_n(b_we_n), .sram_oe_n(b_oe_n), .wb_en_out(b_wb_en_o), .mem_r_en_out(b_mem_r_o),
    .alu_res_out(b_alu_o), .mem_data_out(b_data_o), .dest_out(b_dest_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: combinational read while oe_n is low, write while we_n is low.
  assign a_dq_in = a_oe_n ? 16'h0000 : mem_a[a_addr];
  assign b_dq_in = b_oe_n ? 16'h0000 : mem_b[b_addr];

  always @(posedge clk) begin
    if (!a_we_n && a_dq_oe) mem_a[a_addr] <= a_dq_out;
    if (!b_we_n && b_dq_oe) mem_b[b_addr] <= b_dq_out;
  end

  task automatic clear_a();
    a_wb_en = 1'b0; a_mem_r = 1'b0; a_mem_w = 1'b0;
    a_alu = 32'h0; a_st = 32'h0; a_dest = 4'h0;
  endtask

  task automatic clear_b();
    b_wb_en = 1'b0; b_mem_r = 1'b0; b_mem_w = 1'b0;
    b_alu = 32'h0; b_st = 32'h0; b_dest = 4'h0;
  endtask

  // Counts cycles with ready low; returns at the negedge where ready is high again.
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    @(negedge clk);
    while (((sel ? b_ready : a_ready) == 1'b0) && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_a();
    clear_b();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_ready, a_we_n, a_oe_n, a_dq_oe} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_strobes: got ready/we_n/oe_n/dq_oe=%b exp 1110", {a_ready, a_we_n, a_oe_n, a_dq_oe});
    end
    checks++;
    if ({a_wb_en_o, a_mem_r_o, a_alu_o, a_data_o, a_dest_o} !== 70'h0) begin
      errors++;
      $display("FAIL reset_memwb: got %h exp 0", {a_wb_en_o, a_mem_r_o, a_alu_o, a_data_o, a_dest_o});
    end
    checks++;
    if ({a_addr, a_dq_out} !== 34'h0) begin
      errors++;
      $display("FAIL reset_sram_bus: got addr=%h dq=%h exp 0", a_addr, a_dq_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_alu_op();
    @(posedge clk); #1;
    a_wb_en = 1'b1; a_alu = 32'd5; a_dest = 4'd3;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_ready: got %b exp 1", a_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({a_wb_en_o, a_mem_r_o, a_alu_o, a_dest_o} !== {1'b1, 1'b0, 32'd5, 4'd3}) begin
      errors++;
      $display("FAIL alu_memwb: got wb=%b mr=%b alu=%0d dest=%0d exp 1 0 5 3", a_wb_en_o, a_mem_r_o, a_alu_o, a_dest_o);
    end
    clear_a();
  endtask

  task automatic test_store();
    int n = 0, we_lo = 0, we_hi = 0, bad = 0;
    logic last_lo = 1'b0, last_hi = 1'b0;
    a_mem_w = 1'b1; a_alu = 32'd1032; a_st = 32'hDEAD_BEEF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_ready) break;
      n++;
      if (c >= 1 && c <= 4) begin
        if (a_addr !== 18'd4 || a_dq_out !== 16'hBEEF || a_dq_oe !== 1'b1 || a_oe_n !== 1'b1) bad++;
        if (a_we_n === 1'b0) we_lo++;
        if (c == 4) last_lo = a_we_n;
      end else if (c >= 5 && c <= 8) begin
        if (a_addr !== 18'd5 || a_dq_out !== 16'hDEAD || a_dq_oe !== 1'b1 || a_oe_n !== 1'b1) bad++;
        if (a_we_n === 1'b0) we_hi++;
        if (c == 8) last_hi = a_we_n;
      end
    end
    checks++;
    if (n !== 9) begin errors++; $display("FAIL str_stall: got %0d cycles exp 9", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL str_bus: got %0d bad cycles exp 0", bad); end
    checks++;
    if ({we_lo, we_hi} !== {32'd3, 32'd3} || {last_lo, last_hi} !== 2'b11) begin
      errors++;
      $display("FAIL str_we_n: got lo=%0d hi=%0d last=%b exp 3 3 11", we_lo, we_hi, {last_lo, last_hi});
    end
    @(posedge clk); #1;
    clear_a();
    checks++;
    if ({mem_a[5], mem_a[4]} !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL str_sram: got %h exp deadbeef", {mem_a[5], mem_a[4]});
    end
  endtask

  task automatic test_load();
    int n = 0, bad = 0;
    a_mem_r = 1'b1; a_wb_en = 1'b1; a_dest = 4'd5; a_alu = 32'd1032;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_ready) break;
      n++;
      if (c >= 1 && c <= 8) begin
        if (a_oe_n !== 1'b0 || a_we_n !== 1'b1 || a_dq_oe !== 1'b0) bad++;
        if (a_addr !== ((c <= 4) ? 18'd4 : 18'd5)) bad++;
      end
    end
    checks++;
    if (n !== 9) begin errors++; $display("FAIL ldr_stall: got %0d cycles exp 9", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ldr_bus: got %0d bad samples exp 0", bad); end
    @(posedge clk); #1;
    clear_a();
    checks++;
    if (a_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ldr_data: got %h exp deadbeef", a_data_o);
    end
    checks++;
    if ({a_wb_en_o, a_mem_r_o, a_alu_o, a_dest_o} !== {1'b1, 1'b1, 32'd1032, 4'd5}) begin
      errors++;
      $display("FAIL ldr_memwb: got wb=%b mr=%b alu=%0d dest=%0d exp 1 1 1032 5", a_wb_en_o, a_mem_r_o, a_alu_o, a_dest_o);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    a_mem_r = 1'b1; a_wb_en = 1'b1; a_dest = 4'd7; a_alu = 32'd1036;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if ({a_oe_n, a_addr} !== {1'b0, 18'd7}) begin
      errors++;
      $display("FAIL rstmid_pre: got oe_n=%b addr=%0d exp 0 7", a_oe_n, a_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({a_ready, a_we_n, a_oe_n, a_dq_oe} !== 4'b1110) begin
      errors++;
      $display("FAIL rstmid_strobes: got %b exp 1110", {a_ready, a_we_n, a_oe_n, a_dq_oe});
    end
    checks++;
    if ({a_wb_en_o, a_mem_r_o, a_alu_o, a_data_o, a_dest_o, a_addr, a_dq_out} !== 104'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got addr=%h data=%h alu=%h exp 0", a_addr, a_data_o, a_alu_o);
    end
    clear_a();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, a_oe_n, a_we_n, a_addr} !== {3'b111, 18'd0}) begin
      errors++;
      $display("FAIL rstmid_idle: got ready/oe_n/we_n=%b addr=%0d exp 111 0", {a_ready, a_oe_n, a_we_n}, a_addr);
    end
    @(posedge clk); #1;
    a_mem_r = 1'b1; a_wb_en = 1'b1; a_dest = 4'd7; a_alu = 32'd1036;
    wait_done(1'b0, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL rstmid_restart_stall: got %0d exp 9", n); end
    @(posedge clk); #1;
    clear_a();
    checks++;
    if (a_data_o !== 32'h5678_1234) begin
      errors++;
      $display("FAIL rstmid_restart_data: got %h exp 56781234", a_data_o);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    @(posedge clk); #1;
    b_mem_r = 1'b1; b_wb_en = 1'b1; b_dest = 4'd2; b_alu = 32'd1032;
    wait_done(1'b1, n1);
    checks++;
    if (n1 !== 5) begin errors++; $display("FAIL b2b_ldr_stall: got %0d exp 5", n1); end
    @(posedge clk); #1;
    b_mem_r = 1'b0; b_mem_w = 1'b1; b_wb_en = 1'b0; b_dest = 4'd0;
    b_alu = 32'd1036; b_st = 32'h1357_2468;
    checks++;
    if ({b_data_o, b_mem_r_o, b_wb_en_o, b_dest_o} !== {32'h5555_AAAA, 1'b1, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL b2b_ldr_memwb: got data=%h mr=%b wb=%b dest=%0d exp 5555aaaa 1 1 2", b_data_o, b_mem_r_o, b_wb_en_o, b_dest_o);
    end
    wait_done(1'b1, n2);
    checks++;
    if (n2 !== 5) begin errors++; $display("FAIL b2b_str_stall: got %0d exp 5", n2); end
    @(posedge clk); #1;
    clear_b();
    checks++;
    if ({mem_b[7], mem_b[6]} !== 32'h1357_2468) begin
      errors++;
      $display("FAIL b2b_str_sram: got %h exp 13572468", {mem_b[7], mem_b[6]});
    end
    checks++;
    if ({b_mem_r_o, b_alu_o, b_data_o} !== {1'b0, 32'd1036, 32'h5555_AAAA}) begin
      errors++;
      $display("FAIL b2b_str_memwb: got mr=%b alu=%0d data=%h exp 0 1036 5555aaaa", b_mem_r_o, b_alu_o, b_data_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mem_a[6] = 16'h1234;
    mem_a[7] = 16'h5678;
    mem_b[4] = 16'hAAAA;
    mem_b[5] = 16'h5555;
    test_reset();
    test_alu_op();
    test_store();
    test_load();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
